// File: rtl/uflash_pkg.sv
// Shared types and constants for the user-flash stream programming engine.
package uflash_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StErase,
        StGap,
        StCollect,
        StProg,
        StVerify,
        StFinish
    } state_e;

    localparam logic [1:0] ERR_OK     = 2'd0;
    localparam logic [1:0] ERR_PAGE   = 2'd1;
    localparam logic [1:0] ERR_OVF    = 2'd2;
    localparam logic [1:0] ERR_VERIFY = 2'd3;

    localparam int unsigned PAGES      = 38;
    localparam int unsigned PAGE_WORDS = 512;
    localparam logic [7:0]  ERASED_BYTE = 8'hFF;

    // Controller request encodings carried on f_wstrb.
    localparam logic [3:0] WSTRB_ERASE = 4'b0001;
    localparam logic [3:0] WSTRB_PROG  = 4'b1111;
    localparam logic [3:0] WSTRB_READ  = 4'b0000;

endpackage

// File: rtl/uflash_byte_packer.sv
// Packs accepted stream bytes little-endian into a 32-bit word, padding with
// the erased value when the stream ends mid-word.
module uflash_byte_packer
    import uflash_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic [31:0] word,
    output logic        word_ready,
    output logic        last
);

    logic [1:0]  lane_q, lane_d;
    logic [31:0] buf_q, buf_d;
    logic        last_q, last_d;

    // Lane fill, end-of-stream padding and clear.
    always_comb begin
        lane_d = lane_q;
        buf_d  = buf_q;
        last_d = last_q;
        if (clear) begin
            lane_d = 2'd0;
            last_d = 1'b0;
            buf_d  = {4{ERASED_BYTE}};
        end else if (in_valid) begin
            for (int i = 0; i < 4; i++) begin
                if (2'(i) == lane_q) begin
                    buf_d[8*i +: 8] = in_data;
                end else if (in_last && (2'(i) > lane_q)) begin
                    buf_d[8*i +: 8] = ERASED_BYTE;
                end
            end
            lane_d = lane_q + 2'd1;
            last_d = in_last;
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane_q <= 2'd0;
            buf_q  <= {4{ERASED_BYTE}};
            last_q <= 1'b0;
        end else begin
            lane_q <= lane_d;
            buf_q  <= buf_d;
            last_q <= last_d;
        end
    end

    // Word completes on the accept that fills lane 3 or carries the last byte.
    assign word_ready = in_valid & ((lane_q == 2'd3) | in_last);
    assign word       = buf_q;
    assign last       = last_q;

endmodule

// File: rtl/uflash_stream_writer.sv
// Erases one flash page, then programs and read-back-verifies a byte stream
// into it word by word through the uflash controller bus.
module uflash_stream_writer
    import uflash_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 5400000,
    parameter int unsigned GAP_MS   = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [5:0]  page,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        s_ready,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err,
    output logic        f_sel,
    output logic [3:0]  f_wstrb,
    output logic [14:0] f_addr,
    output logic [31:0] f_wdata,
    input  logic        f_ready,
    input  logic [31:0] f_rdata
);

    localparam logic [23:0] GapClks = 24'((64'(CLK_FREQ) * 64'(GAP_MS)) / 64'd1000);
    localparam logic [23:0] GapEnd  = (GapClks == 24'd0) ? 24'd0 : GapClks - 24'd1;

    state_e      state_q, state_d;
    logic [5:0]  page_q, page_d;
    logic [8:0]  widx_q, widx_d;
    logic [23:0] gap_q, gap_d;
    logic        sel_q, sel_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [14:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [1:0]  err_q, err_d;

    logic        accept;
    logic        pk_clear;
    logic [31:0] pk_word;
    logic        pk_ready;
    logic        pk_last;

    assign s_ready = (state_q == StCollect);
    assign accept  = s_valid & s_ready;

    uflash_byte_packer u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (pk_clear),
        .in_valid   (accept),
        .in_data    (s_data),
        .in_last    (s_last),
        .word       (pk_word),
        .word_ready (pk_ready),
        .last       (pk_last)
    );

    // Sequencing and bus requests. Each bus state first raises f_sel with its
    // fields in one update, then drops it on the f_ready edge while advancing.
    always_comb begin
        state_d  = state_q;
        page_d   = page_q;
        widx_d   = widx_q;
        gap_d    = gap_q;
        sel_d    = sel_q;
        wstrb_d  = wstrb_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        pk_clear = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    busy_d = 1'b1;
                    page_d = page;
                    if (page < 6'(PAGES)) begin
                        err_d   = ERR_OK;
                        state_d = StErase;
                    end else begin
                        err_d   = ERR_PAGE;
                        state_d = StFinish;
                    end
                end
            end
            StErase: begin
                if (!sel_q) begin
                    sel_d   = 1'b1;
                    wstrb_d = WSTRB_ERASE;
                    addr_d  = {page_q, 9'd0};
                end else if (f_ready) begin
                    sel_d   = 1'b0;
                    gap_d   = 24'd0;
                    state_d = StGap;
                end
            end
            StGap: begin
                if (gap_q >= GapEnd) begin
                    widx_d   = 9'd0;
                    pk_clear = 1'b1;
                    state_d  = StCollect;
                end else begin
                    gap_d = gap_q + 24'd1;
                end
            end
            StCollect: begin
                if (pk_ready) begin
                    state_d = StProg;
                end
            end
            StProg: begin
                if (!sel_q) begin
                    sel_d   = 1'b1;
                    wstrb_d = WSTRB_PROG;
                    addr_d  = {page_q, widx_q};
                    wdata_d = pk_word;
                end else if (f_ready) begin
                    sel_d   = 1'b0;
                    state_d = StVerify;
                end
            end
            StVerify: begin
                if (!sel_q) begin
                    sel_d   = 1'b1;
                    wstrb_d = WSTRB_READ;
                    addr_d  = {page_q, widx_q};
                end else if (f_ready) begin
                    sel_d = 1'b0;
                    if (f_rdata != pk_word) begin
                        err_d   = ERR_VERIFY;
                        state_d = StFinish;
                    end else if (pk_last) begin
                        err_d   = ERR_OK;
                        state_d = StFinish;
                    end else if (widx_q == 9'(PAGE_WORDS - 1)) begin
                        // Page full with stream still open: leave the rest unread.
                        err_d   = ERR_OVF;
                        state_d = StFinish;
                    end else begin
                        widx_d   = widx_q + 9'd1;
                        pk_clear = 1'b1;
                        state_d  = StCollect;
                    end
                end
            end
            StFinish: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            page_q  <= 6'd0;
            widx_q  <= 9'd0;
            gap_q   <= 24'd0;
            sel_q   <= 1'b0;
            wstrb_q <= 4'd0;
            addr_q  <= 15'd0;
            wdata_q <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= ERR_OK;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            widx_q  <= widx_d;
            gap_q   <= gap_d;
            sel_q   <= sel_d;
            wstrb_q <= wstrb_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign f_sel   = sel_q;
    assign f_wstrb = wstrb_q;
    assign f_addr  = addr_q;
    assign f_wdata = wdata_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_uflash_stream_writer.sv
// Randomized bench for uflash_stream_writer with a simple flash responder and
// a transaction-level expectation list built from the byte stream.
module tb_uflash_stream_writer;

    localparam int unsigned CLK_FREQ = 20000;
    localparam int unsigned GAP_MS   = 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  page = 6'd0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'd0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic        busy;
    logic        done;
    logic [1:0]  err;
    logic        f_sel;
    logic [3:0]  f_wstrb;
    logic [14:0] f_addr;
    logic [31:0] f_wdata;
    logic        f_ready;
    logic [31:0] f_rdata;

    uflash_stream_writer #(
        .CLK_FREQ (CLK_FREQ),
        .GAP_MS   (GAP_MS)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .page    (page),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_last  (s_last),
        .s_ready (s_ready),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .f_sel   (f_sel),
        .f_wstrb (f_wstrb),
        .f_addr  (f_addr),
        .f_wdata (f_wdata),
        .f_ready (f_ready),
        .f_rdata (f_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  strb;
        logic [14:0] addr;
        logic [31:0] data;
    } acc_t;

    acc_t        exp_q[$];
    logic [7:0]  stim_q[$];
    logic [31:0] mem [0:19455];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_err = 0;
    int exp_consumed = 0;
    int rd_total = 0, rd_base = 0;
    int acc_total = 0, acc_base = 0;
    int done_total = 0, done_base = 0, done_cyc = 0;
    int read_cnt = 0, read_base = 0;
    int lat_cnt = 0, lat_tgt = 0;
    int last_latency = 0;
    bit inject = 1'b0;
    logic [14:0] last_prog_addr = 15'd0;
    logic        prev_sel = 1'b0;
    logic [3:0]  prev_strb = 4'd0;
    logic [14:0] prev_addr = 15'd0;
    logic [31:0] prev_wdata = 32'd0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Flash responder: random latency, one f_ready pulse per request.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f_ready <= 1'b0;
            f_rdata <= 32'd0;
            lat_cnt <= 0;
            lat_tgt <= 0;
        end else begin
            f_ready <= 1'b0;
            if (f_sel && !f_ready) begin
                if (lat_cnt >= lat_tgt) begin
                    f_ready <= 1'b1;
                    lat_cnt <= 0;
                    lat_tgt <= int'($urandom_range(0, 3));
                    if (f_wstrb == 4'b0001) begin
                        for (int i = 0; i < 512; i++) mem[int'(f_addr[14:9]) * 512 + i] <= 32'hFFFF_FFFF;
                    end else if (f_wstrb == 4'b1111) begin
                        mem[f_addr] <= f_wdata;
                    end else begin
                        f_rdata  <= mem[f_addr] ^ {31'd0, (inject && read_cnt == read_base)};
                        read_cnt <= read_cnt + 1;
                    end
                end else begin
                    lat_cnt <= lat_cnt + 1;
                end
            end
        end
    end

    // Expected access list, error code and consumed byte count for a transfer.
    task automatic plan(input int pg, input bit with_last);
        int   n;
        int   nw;
        acc_t a;
        logic [31:0] word;
        n = stim_q.size();
        exp_q.delete();
        if (pg >= 38) begin
            exp_err = 1;
            exp_consumed = 0;
            return;
        end
        a.strb = 4'b0001; a.addr = 15'(pg * 512); a.data = 32'd0;
        exp_q.push_back(a);
        if (with_last) begin
            nw = (n + 3) / 4; exp_consumed = n; exp_err = 0;
        end else begin
            nw = 512; exp_consumed = 2048; exp_err = 2;
        end
        if (inject) begin
            nw = 1; exp_consumed = (n < 4) ? n : 4; exp_err = 3;
        end
        for (int w = 0; w < nw; w++) begin
            for (int b = 0; b < 4; b++) begin
                word[8*b +: 8] = (4*w + b < n) ? stim_q[4*w + b] : 8'hFF;
            end
            a.strb = 4'b1111; a.addr = 15'(pg * 512 + w); a.data = word;
            exp_q.push_back(a);
            a.strb = 4'b0000; a.data = 32'd0;
            exp_q.push_back(a);
        end
    endtask

    // Compare process: bus accesses, request stability, busy, and completion.
    always @(negedge clk) begin : cmp
        int i;
        if (reset_n) begin
            if (f_sel && prev_sel)
                check("req_stable", 64'({f_wstrb, f_addr, f_wdata}),
                      64'({prev_strb, prev_addr, prev_wdata}));
            if (f_sel && !prev_sel) begin
                i = rd_total - rd_base;
                if (i >= exp_q.size()) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_access: got strb %b addr %h, required none",
                             f_wstrb, f_addr);
                end else begin
                    check("access_strb", 64'(f_wstrb), 64'(exp_q[i].strb));
                    check("access_addr", 64'(f_addr), 64'(exp_q[i].addr));
                    if (exp_q[i].strb == 4'b1111)
                        check("prog_data", 64'(f_wdata), 64'(exp_q[i].data));
                end
                rd_total++;
                if (f_wstrb == 4'b1111) last_prog_addr = f_addr;
            end
            if (f_sel || s_ready) check("busy_active", 64'(busy), 64'd1);
            if (s_valid && s_ready) acc_total++;
            if (done) begin
                done_total++;
                done_cyc = cyc;
                check("err", 64'(err), 64'(exp_err));
                check("bytes_consumed", 64'(acc_total - acc_base), 64'(exp_consumed));
                check("access_count", 64'(rd_total - rd_base), 64'(exp_q.size()));
                check("busy_at_done", 64'(busy), 64'd0);
            end
        end
        prev_sel   = reset_n ? f_sel : 1'b0;
        prev_strb  = f_wstrb;
        prev_addr  = f_addr;
        prev_wdata = f_wdata;
    end

    task automatic begin_xfer(input int pg, input bit with_last, input bit inj);
        inject    = inj;
        read_base = read_cnt;
        plan(pg, with_last);
        rd_base   = rd_total;
        acc_base  = acc_total;
        done_base = done_total;
        start = 1'b1;
        page  = 6'(pg);
    endtask

    task automatic run_xfer(input int pg, input bit with_last, input bit inj);
        int idx;
        int n;
        int cycles;
        int start_cyc;
        idx = 0;
        cycles = 0;
        n = stim_q.size();
        begin_xfer(pg, with_last, inj);
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        while (done_total == done_base && cycles < 30000) begin
            if (idx < n && $urandom_range(0, 3) != 0) begin
                s_valid = 1'b1;
                s_data  = stim_q[idx];
                s_last  = with_last && (idx == n - 1);
            end else begin
                s_valid = 1'b0;
                s_last  = 1'b0;
            end
            @(negedge clk);
            if (s_valid && s_ready) idx++;
            @(posedge clk); #1;
            cycles++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (done_total == done_base) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles, required done", cycles);
        end else begin
            last_latency = done_cyc - start_cyc;
            repeat (3) @(posedge clk);
            #1;
            check("done_pulses", 64'(done_total - done_base), 64'd1);
        end
    endtask

    task automatic fill_random(input int n);
        stim_q.delete();
        for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom));
    endtask

    initial begin : main
        int waited;
        #1;
        check("reset_outputs_init", 64'({s_ready, busy, done, err, f_sel, f_wstrb, f_addr, f_wdata}),
              64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Page 3, bytes 01..08.
        stim_q.delete();
        for (int i = 1; i <= 8; i++) stim_q.push_back(8'(i));
        run_xfer(3, 1'b1, 1'b0);
        check("p3_word0", 64'(mem[15'h0600]), 64'h0403_0201);
        check("p3_word1", 64'(mem[15'h0601]), 64'h0807_0605);

        // Page 0, five bytes with padding.
        stim_q.delete();
        stim_q.push_back(8'hAA); stim_q.push_back(8'hBB); stim_q.push_back(8'hCC);
        stim_q.push_back(8'hDD); stim_q.push_back(8'hEE);
        run_xfer(0, 1'b1, 1'b0);
        check("p0_word0", 64'(mem[15'h0000]), 64'hDDCC_BBAA);
        check("p0_word1", 64'(mem[15'h0001]), 64'hFFFF_FFEE);

        // Page 37 overflow with 2049 bytes and no s_last.
        fill_random(2049);
        run_xfer(37, 1'b0, 1'b0);
        check("ovf_last_addr", 64'(last_prog_addr), 64'h4BFF);
        check("ovf_last_word", 64'(mem[15'h4BFF]),
              64'({stim_q[2047], stim_q[2046], stim_q[2045], stim_q[2044]}));

        // Bad page.
        fill_random(4);
        run_xfer(38, 1'b1, 1'b0);
        check("badpage_latency", 64'(last_latency), 64'd2);

        // Verify mismatch on the first read-back.
        fill_random(12);
        run_xfer(10, 1'b1, 1'b1);

        // Reset during the guard gap, then a full transfer.
        fill_random(16);
        begin_xfer(5, 1'b1, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        waited = 0;
        while (!(f_sel && f_ready && f_wstrb == 4'b0001) && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 2000) begin
            checks++;
            errors++;
            $display("FAIL erase_timeout: got no erase completion, required one");
        end
        repeat (5) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_outputs_gap", 64'({s_ready, busy, done, err, f_sel, f_wstrb, f_addr, f_wdata}),
              64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_xfer(5, 1'b1, 1'b0);
        check("after_reset_w0", 64'(mem[15'h0A00]),
              64'({stim_q[3], stim_q[2], stim_q[1], stim_q[0]}));

        // Random transfers, including a random out-of-range page.
        for (int t = 0; t < 6; t++) begin
            fill_random(int'($urandom_range(1, 40)));
            run_xfer(int'($urandom_range(0, 37)), 1'b1, 1'b0);
        end
        fill_random(3);
        run_xfer(int'($urandom_range(38, 63)), 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uflash_stream_writer.md
# uflash_stream_writer

Upstream programming engine for the user-flash controller (`uflash`). It accepts a byte stream with a valid/ready handshake and erases one 2048-byte flash page. It then packs the bytes little-endian into 32-bit words, programs them sequentially, and reads back each word to verify it. It drives the controller's `sel`/`wstrb`/`addr`/`data_i`/`ready`/`data_o` bus directly and replaces a CPU-driven programming loop, for example behind a UART loader.

## Interface
- `CLK_FREQ`, default 5400000: system clock in Hz. Must match the `uflash` instance.
- `GAP_MS`, default 10: guard time in ms between erase completion and the first program.
- `clk`  in  1  system clock (≤40 MHz).
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request. Sampled only in IDLE.
- `page`  in  6  page index 0..37. Captured with `start`.
- `s_valid` / `s_data` / `s_last`  in  1/8/1  byte stream. `s_last` marks the final byte.
- `s_ready`  out  1  byte accepted on a cycle where `s_valid & s_ready`.
- `busy`  out  1  high from an accepted `start` until `done`.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  2  result, valid from `done` until the next `start`: 0 OK, 1 bad page, 2 overflow, 3 verify mismatch.
- `f_sel` / `f_wstrb` / `f_addr` / `f_wdata`  out  1/4/15/32  controller request, registered.
- `f_ready` / `f_rdata`  in  1/32  controller completion and read data.

## Operation
- Page p covers word addresses p*512 .. p*512+511. Word counter `widx` is 9 bits.
- States: IDLE, ERASE, GAP, COLLECT, PROG, VERIFY, FINISH.
- IDLE → ERASE on `start` when `page` ≤ 37.
  - `start` with `page` > 37 → FINISH with `err`=1. No flash access occurs.
  - `start` while `busy` is ignored.
- ERASE: issue `f_wstrb`=0001, `f_addr`=page*512.
- GAP: count GAP_CLKS = CLK_FREQ*GAP_MS/1000 cycles (24-bit counter), then enter COLLECT with `widx`=0.
- COLLECT: `s_ready`=1. Bytes fill lanes 0→3 of the word buffer.
  - After lane 3 is accepted, or after `s_last` is accepted, go to PROG.
  - On `s_last`, unfilled lanes are padded with 8'hFF (the erased value) and a `last` flag is latched.
- PROG: `f_wstrb`=1111, `f_addr`=page*512+widx, `f_wdata`=buffer.
- VERIFY: `f_wstrb`=0000, same address. Compare `f_rdata` captured on `f_ready` against the buffer.
  - Mismatch → FINISH with `err`=3.
  - Match with `last` set → FINISH with `err`=0.
  - Match with `widx`=511 and no `last` → FINISH with `err`=2. Unconsumed bytes stay in the stream.
  - Otherwise increment `widx` and return to COLLECT.
- FINISH: pulse `done`, drop `busy`, go to IDLE.
- Zero-byte transfers are not supported. The transfer ends only on `s_last` or a full page.

## Timing
- Bus rule, applied to every flash access:
  - Set `f_sel`=1 and the other request fields in one registered update, then hold them stable.
  - On the edge where `f_ready`=1, clear `f_sel` and advance state.
  - `f_sel` is therefore low in the controller's following IDLE cycle, so no access is issued twice.
- `s_ready` is combinational from state (COLLECT only). It is low in the cycle after the fourth or final byte is accepted.
- `done` is high exactly one cycle. `busy` falls in the same cycle.
- Reset values: `s_ready`=0, `busy`=0, `done`=0, `err`=0, `f_sel`=0, `f_wstrb`=0, `f_addr`=0, `f_wdata`=0. The FSM resets to IDLE.
- Reset during an operation abandons it. The flash controller shares `reset_n`, so the page contents are then undefined and the page must be re-erased.
- Minimum latency: ≈ erase time (120 ms) + GAP + 512 × (program ≈ 50 µs + read ≈ 4 cycles).

## Structure
- The `uflash_pkg` package holds:
  - the state enum;
  - the error codes (`ERR_OK`, `ERR_PAGE`, `ERR_OVF`, `ERR_VERIFY`);
  - `PAGES`=38, `PAGE_WORDS`=512, `ERASED_BYTE`=8'hFF.
- Sub-module `uflash_byte_packer`: a 4-lane buffer with lane counter, `s_last` padding, and word-ready flag. It is cleared by the FSM.
- The top-level bench instantiates this block and `uflash` against the flash simulation model.

## Test plan
- `page`=3, 8 bytes 01..08 with `s_last` on 08 → erase at 0x0600; words 0x04030201 @0x0600 and 0x08070605 @0x0601; `done`, `err`=0.
- `page`=0, 5 bytes AA,BB,CC,DD,EE (last) → second word 0xFFFFFFEE @0x0001; `err`=0.
- `page`=37, 2049 bytes without `s_last` → 512 words written ending @0x4BFF; `err`=2; byte 2049 not accepted (`s_ready`=0).
- `page`=38 → `done` two cycles after `start`, `err`=1, `f_sel` never asserted.
- Force `f_rdata` bit 0 flipped on the first verify → `err`=3 after one word; no further `f_sel`.
- Assert `reset_n` low mid-GAP → all outputs at reset values next cycle. A new `start` then performs a full erase.
